// File: rtl/aes_loader_pkg.sv
// Shared types and constants for the AES byte-stream input loader.
// Pure definitions: no logic, no latency, no flow control.
package aes_loader_pkg;

  typedef enum logic [1:0] {
    LOAD_STATE = 2'd0,
    LOAD_KEY   = 2'd1,
    HOLD       = 2'd2,
    DISCARD    = 2'd3
  } loader_state_t;

  localparam int         FRAME_BYTES = 32;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/aes_byte_loader_shift128.sv
// 128-bit byte shift register: shifts left one byte and inserts at the LSB when enabled.
// One-cycle update on en; no backpressure (caller gates en with the accept).
module byte_shift128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [7:0]   data,
  output logic [127:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= {q[119:0], data};
    end
  end

endmodule

// File: rtl/aes_byte_loader.sv
// Assembles a 32-byte valid/ready stream frame (state then key) into two 128-bit words.
// out_valid rises the cycle after byte 31; in_ready drops while a frame is held for out_ready.
module aes_byte_loader
  import aes_loader_pkg::*;
#(
  parameter int BLOCK_BYTES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [127:0] state_out,
  output logic [127:0] key_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err,
  output logic [7:0]   err_cnt
);

  localparam logic [4:0] LAST_STATE_IDX = 5'(BLOCK_BYTES - 1);
  localparam logic [4:0] LAST_IDX       = 5'(FRAME_BYTES - 1);

  loader_state_t state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic          accept;
  logic          err_d;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    case (state_q)
      LOAD_STATE: begin
        if (accept) begin
          if (in_last) begin
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            idx_d = idx_q + 5'd1;
            if (idx_q == LAST_STATE_IDX) state_d = LOAD_KEY;
          end
        end
      end
      LOAD_KEY: begin
        if (accept) begin
          // Byte 31 either completes the frame or starts a discard; never both.
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (in_last) begin
              state_d = HOLD;
            end else begin
              err_d   = 1'b1;
              state_d = DISCARD;
            end
          end else if (in_last) begin
            err_d   = 1'b1;
            idx_d   = '0;
            state_d = LOAD_STATE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = LOAD_STATE;
          idx_d   = '0;
        end
      end
      DISCARD: begin
        if (accept && in_last) state_d = LOAD_STATE;
      end
      default: begin
        state_d = LOAD_STATE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD_STATE;
      idx_q   <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err     <= err_d;
      if (err_d && (err_cnt != ERR_CNT_MAX)) err_cnt <= err_cnt + 8'd1;
    end
  end

  byte_shift128 u_state_sr (
    .clk  (clk),
    .rst  (rst),
    .en   (accept && (state_q == LOAD_STATE)),
    .data (in_data),
    .q    (state_out)
  );

  byte_shift128 u_key_sr (
    .clk  (clk),
    .rst  (rst),
    .en   (accept && (state_q == LOAD_KEY)),
    .data (in_data),
    .q    (key_out)
  );

endmodule

// File: tb/tb_aes_byte_loader.sv
// Directed + randomized bench for aes_byte_loader; expected words and error counts come
// from a frame-level model (byte array packing, length rules, saturating counter).
module tb_aes_byte_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [127:0] state_out;
  logic [127:0] key_out;
  logic         out_valid;
  logic         out_ready;
  logic         err;
  logic [7:0]   err_cnt;

  int checks = 0;
  int errors = 0;
  int model_errs = 0;
  logic [7:0] fb [0:63];

  aes_byte_loader #(.BLOCK_BYTES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .state_out (state_out),
    .key_out   (key_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bytes fb[base..base+15] with the first byte landing in the top byte.
  function automatic logic [127:0] pack(input int base);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v = v | (128'(fb[base + i]) << (8 * (15 - i)));
    return v;
  endfunction

  task automatic randomize_frame();
    for (int i = 0; i < 64; i++) fb[i] = 8'($urandom);
  endtask

  // Sends fb[0..n-1]; last_end marks the final byte with in_last. A well-formed
  // frame is then held for 'hold' cycles with junk offered, then handshaken.
  task automatic send_frame(input int n, input bit last_end, input int max_gap, input int hold);
    int  budget;
    int  g;
    bit  good;
    bit  exp_err;
    good = last_end && (n == 32);
    for (int i = 0; i < n; i++) begin
      if (max_gap > 0) begin
        g = int'($urandom_range(max_gap, 0));
        repeat (g) @(negedge clk);
      end
      in_data  = fb[i];
      in_last  = last_end && (i == n - 1);
      in_valid = 1'b1;
      budget   = 0;
      while (!in_ready && budget < 50) begin
        @(negedge clk);
        budget++;
      end
      if (!in_ready) begin
        chk("in_ready_timeout", 128'(in_ready), 128'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      exp_err  = last_end && (((n < 32) && (i == n - 1)) || ((n > 32) && (i == 31)));
      if (exp_err) model_errs = (model_errs < 255) ? model_errs + 1 : 255;
      chk("err", 128'(err), 128'(exp_err));
      chk("out_valid", 128'(out_valid), 128'(good && (i == n - 1)));
    end
    if (last_end) chk("err_cnt", 128'(err_cnt), 128'(model_errs));
    if (good) begin
      chk("in_ready_in_hold", 128'(in_ready), 128'd0);
      chk("state_out", state_out, pack(0));
      chk("key_out", key_out, pack(16));
      for (int c = 0; c < hold; c++) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hEE;
        @(negedge clk);
        chk("hold_out_valid", 128'(out_valid), 128'd1);
        chk("hold_in_ready", 128'(in_ready), 128'd0);
        chk("hold_state_out", state_out, pack(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_hs_out_valid", 128'(out_valid), 128'd0);
      chk("post_hs_in_ready", 128'(in_ready), 128'd1);
      chk("post_hs_key_out", key_out, pack(16));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_state_out", state_out, 128'd0);
    chk("rst_key_out", key_out, 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_err_cnt", 128'(err_cnt), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    rst = 1'b1;

    // Basic counting frame 0x00..0x1F, out_ready held high throughout.
    for (int i = 0; i < 64; i++) fb[i] = 8'(i);
    send_frame(32, 1'b1, 0, 0);

    // Backpressure for 10 cycles, then a fresh frame.
    randomize_frame();
    send_frame(32, 1'b1, 0, 10);
    randomize_frame();
    send_frame(32, 1'b1, 0, 0);

    // in_last on byte 20, then a correct frame.
    randomize_frame();
    send_frame(21, 1'b1, 0, 0);
    randomize_frame();
    send_frame(32, 1'b1, 0, 0);

    // 40-byte frame: error after byte 31, tail discarded.
    randomize_frame();
    send_frame(40, 1'b1, 0, 0);
    randomize_frame();
    send_frame(32, 1'b1, 0, 0);

    // Counter saturation with one-byte frames.
    for (int f = 0; f < 260; f++) begin
      fb[0] = 8'($urandom);
      send_frame(1, 1'b1, 0, 0);
    end
    chk("err_cnt_saturated", 128'(err_cnt), 128'd255);

    // Reset after byte 10 of a frame.
    randomize_frame();
    send_frame(11, 1'b0, 0, 0);
    rst = 1'b0;
    #1;
    chk("midrst_state_out", state_out, 128'd0);
    chk("midrst_key_out", key_out, 128'd0);
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_err", 128'(err), 128'd0);
    chk("midrst_err_cnt", 128'(err_cnt), 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    model_errs = 0;
    @(negedge clk);
    rst = 1'b1;
    randomize_frame();
    send_frame(32, 1'b1, 0, 0);

    // Random in_valid gaps of 0..5 cycles, with and without backpressure.
    randomize_frame();
    send_frame(32, 1'b1, 5, 0);
    randomize_frame();
    send_frame(32, 1'b1, 5, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
